// File: rtl/add_pkt_hdr.sv
// add_pkt_hdr: store-and-forward inserter that prepends a length/source-port header word to
// each buffered packet. Define ADD_PKT_HDR_RUNT_DROP_EN to drop packets shorter than 60 bytes.
module add_pkt_hdr #(
   parameter int unsigned DATA_WIDTH      = 64,
   parameter int unsigned CTRL_WIDTH      = DATA_WIDTH / 8,
   parameter logic [15:0] SRC_PORT        = 16'd0,
   parameter logic [7:0]  HDR_CTRL        = 8'hFF,
   parameter int unsigned DATA_FIFO_DEPTH = 512,
   parameter int unsigned LEN_FIFO_DEPTH  = 16,
   parameter int unsigned MAX_PKT_WORDS   = 200
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_eop,
   input  logic [2:0]            in_last_bytes,
   input  logic                  in_wr,
   output logic                  in_rdy,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CTRL_WIDTH-1:0] out_ctrl,
   output logic                  out_wr,
   input  logic                  out_rdy,
`ifdef ADD_PKT_HDR_RUNT_DROP_EN
   output logic                  runt_drop,
`endif
   output logic                  trunc_err
);

   localparam int unsigned DAW = $clog2(DATA_FIFO_DEPTH);
   localparam int unsigned LAW = $clog2(LEN_FIFO_DEPTH);
   localparam logic [DAW:0] DataOne  = (DAW+1)'(1);
   localparam logic [DAW:0] MaxUsed  = (DAW+1)'(DATA_FIFO_DEPTH - 2);
   localparam logic [LAW:0] LenOne   = (LAW+1)'(1);
   localparam logic [LAW:0] LenDepth = (LAW+1)'(LEN_FIFO_DEPTH);
   localparam logic [15:0]  MaxWords = 16'(MAX_PKT_WORDS);
   localparam logic [15:0]  MaxBytes = 16'(MAX_PKT_WORDS * 8);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StHdr  = 2'd1;
   localparam logic [1:0] StBody = 2'd2;

   logic [DATA_WIDTH-1:0] data_mem [DATA_FIFO_DEPTH];
   logic [31:0]           len_mem  [LEN_FIFO_DEPTH];  // {word_len, byte_len}

   logic [DAW:0]  wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d, used;
   logic [LAW:0]  len_wr_ptr_q, len_wr_ptr_d, len_rd_ptr_q, len_rd_ptr_d;
   logic [15:0]   wcnt_q, wcnt_d, rcnt_q, rcnt_d, push_wlen, push_blen, lb;
   logic [31:0]   head;
   logic [1:0]    state_q, state_d;
   logic          accept, store, len_push, len_empty, len_full, alive_q;
   logic          trunc_q, trunc_d, out_wr_q, out_wr_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;
`ifdef ADD_PKT_HDR_RUNT_DROP_EN
   logic          runt_q, runt_d;
   assign runt_drop = runt_q;
`endif

   assign used      = wr_ptr_q - rd_ptr_q;
   assign len_empty = (len_wr_ptr_q == len_rd_ptr_q);
   assign len_full  = ((len_wr_ptr_q - len_rd_ptr_q) == LenDepth);
   assign in_rdy    = alive_q && (used <= MaxUsed) && !len_full;
   assign accept    = in_wr && in_rdy;
   // Words past MAX_PKT_WORDS are accepted but not stored.
   assign store     = accept && (wcnt_q < MaxWords);
   assign lb        = (in_last_bytes == 3'd0) ? 16'd8 : {13'd0, in_last_bytes};
   assign head      = len_mem[len_rd_ptr_q[LAW-1:0]];

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      wcnt_d       = wcnt_q;
      len_push     = 1'b0;
      trunc_d      = 1'b0;
      push_wlen    = wcnt_q + 16'd1;
      push_blen    = {wcnt_q[12:0], 3'b000} + lb;
`ifdef ADD_PKT_HDR_RUNT_DROP_EN
      runt_d       = 1'b0;
`endif
      if (store) begin
         wr_ptr_d = wr_ptr_q + DataOne;
         wcnt_d   = wcnt_q + 16'd1;
      end
      if (accept && in_eop) begin
         wcnt_d = '0;
         if (!store) begin
            push_wlen = MaxWords;
            push_blen = MaxBytes;
            trunc_d   = 1'b1;
         end
`ifdef ADD_PKT_HDR_RUNT_DROP_EN
         if (push_blen < 16'd60) begin
            wr_ptr_d = commit_ptr_q;
            runt_d   = 1'b1;
         end else begin
            len_push     = 1'b1;
            commit_ptr_d = wr_ptr_d;
         end
`else
         len_push     = 1'b1;
         commit_ptr_d = wr_ptr_d;
`endif
      end
      len_wr_ptr_d = len_push ? (len_wr_ptr_q + LenOne) : len_wr_ptr_q;
   end

   always_comb begin
      state_d      = state_q;
      rd_ptr_d     = rd_ptr_q;
      len_rd_ptr_d = len_rd_ptr_q;
      rcnt_d       = rcnt_q;
      out_wr_d     = 1'b0;
      out_ctrl_d   = '0;
      out_data_d   = out_data_q;
      case (state_q)
         StIdle, StHdr: begin
            if (!len_empty) begin
               if (out_rdy) begin
                  out_wr_d   = 1'b1;
                  out_ctrl_d = CTRL_WIDTH'(HDR_CTRL);
                  out_data_d = DATA_WIDTH'({16'h0000, head[31:16], SRC_PORT, head[15:0]});
                  rcnt_d     = head[31:16];
                  state_d    = StBody;
               end else begin
                  state_d = StHdr;
               end
            end
         end
         StBody: begin
            if (out_rdy && (rd_ptr_q != commit_ptr_q)) begin
               out_wr_d   = 1'b1;
               out_data_d = data_mem[rd_ptr_q[DAW-1:0]];
               rd_ptr_d   = rd_ptr_q + DataOne;
               rcnt_d     = rcnt_q - 16'd1;
               if (rcnt_q == 16'd1) begin
                  len_rd_ptr_d = len_rd_ptr_q + LenOne;
                  // Includes a descriptor pushed this same cycle, so no idle gap.
                  state_d = (len_wr_ptr_d != len_rd_ptr_d) ? StHdr : StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         rd_ptr_q     <= '0;
         len_wr_ptr_q <= '0;
         len_rd_ptr_q <= '0;
         wcnt_q       <= '0;
         rcnt_q       <= '0;
         state_q      <= StIdle;
         alive_q      <= 1'b0;
         trunc_q      <= 1'b0;
         out_wr_q     <= 1'b0;
         out_ctrl_q   <= '0;
         out_data_q   <= '0;
`ifdef ADD_PKT_HDR_RUNT_DROP_EN
         runt_q       <= 1'b0;
`endif
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         len_wr_ptr_q <= len_wr_ptr_d;
         len_rd_ptr_q <= len_rd_ptr_d;
         wcnt_q       <= wcnt_d;
         rcnt_q       <= rcnt_d;
         state_q      <= state_d;
         alive_q      <= 1'b1;
         trunc_q      <= trunc_d;
         out_wr_q     <= out_wr_d;
         out_ctrl_q   <= out_ctrl_d;
         out_data_q   <= out_data_d;
`ifdef ADD_PKT_HDR_RUNT_DROP_EN
         runt_q       <= runt_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (store) data_mem[wr_ptr_q[DAW-1:0]] <= in_data;
      if (len_push) len_mem[len_wr_ptr_q[LAW-1:0]] <= {push_wlen, push_blen};
   end

   assign out_wr    = out_wr_q;
   assign out_ctrl  = out_ctrl_q;
   assign out_data  = out_data_q;
   assign trunc_err = trunc_q;

endmodule
